// File: rtl/aes128_inverse_cipher.sv
`default_nettype none
// ============================================================================
// Module   : aes128_inverse_cipher
// Brief    : Fully unrolled, 11-stage pipelined AES-128 inverse cipher.
// Revision : 1.0
// ============================================================================
module aes128_inverse_cipher #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [0:NK*32-1] key,
    input  logic [0:127]     in,
    input  logic             valid_in,
    output logic [0:127]     out,
    output logic             valid_out
);

    localparam int NW = 4 * (NR + 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        p = gf_mul(a, a);
        r = p;
        for (int i = 0; i < 6; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] s;
        s = gf_inv(a);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]}
                 ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {fwd_sbox(w[31:24]), fwd_sbox(w[23:16]), fwd_sbox(w[15:8]), fwd_sbox(w[7:0])};
    endfunction

    function automatic logic [NW-1:0][31:0] expand_key(input logic [127:0] k);
        logic [NW-1:0][31:0] w;
        logic [31:0]         t;
        logic [7:0]          rc;
        w  = '0;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            w[i] = k[127-32*i -: 32];
        for (int i = 4; i < NW; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = t ^ w[i-4];
        end
        return w;
    endfunction

    // InvMixColumns on one column (byte 0 in the top bits) using xtime chains.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [3:0][7:0] a, m9, mb, md, me;
        logic [7:0]      x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                me[1] ^ mb[2] ^ md[3] ^ m9[0],
                me[2] ^ mb[3] ^ md[0] ^ m9[1],
                me[3] ^ mb[0] ^ md[1] ^ m9[2]};
    endfunction

    // State byte (row r, column c) lives at index 4c+r; byte 0 is the top byte.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
        t = t ^ k;
        if (mix)
            for (int c = 0; c < 4; c++)
                t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
        return t;
    endfunction

    logic [127:0]         w_key;
    logic [127:0]         w_in;
    logic [NW-1:0][31:0]  w_words;
    logic [127:0]         w_last_key;
    logic [127:0]         w_next  [1:NR];
    logic [127:0]         r_state [0:NR];
    logic [NR:0]          r_valid;

    assign w_key      = key;
    assign w_in       = in;
    assign w_words    = expand_key(w_key);
    assign w_last_key = {w_words[4*NR], w_words[4*NR+1], w_words[4*NR+2], w_words[4*NR+3]};

    for (genvar s = 1; s <= NR; s++) begin : g_round
        localparam int RK = NR - s;
        assign w_next[s] = inv_round(r_state[s-1],
                                     {w_words[4*RK], w_words[4*RK+1],
                                      w_words[4*RK+2], w_words[4*RK+3]},
                                     (s != NR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s <= NR; s++)
                r_state[s] <= '0;
        end else begin
            r_valid    <= {r_valid[NR-1:0], valid_in};
            r_state[0] <= w_in ^ w_last_key;
            for (int s = 1; s < NR; s++)
                r_state[s] <= w_next[s];
            // The output register only moves for valid blocks so "out" holds across bubbles.
            if (r_valid[NR-1])
                r_state[NR] <= w_next[NR];
        end
    end

    assign out       = r_state[NR];
    assign valid_out = r_valid[NR];

endmodule
`default_nettype wire

// File: tb/tb_aes128_inverse_cipher.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_inverse_cipher
// Brief    : Scoreboard bench for the pipelined AES-128 inverse cipher.
// Revision : 1.0
// ============================================================================
module tb_aes128_inverse_cipher;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CA  = 128'h0a940bb5416ef045f1c39458c653ea5a;
    localparam logic [127:0] PA  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CB  = 128'h20a9f992b44c5be8041ffcdc6cae996a;
    localparam logic [127:0] PB  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] CC  = 128'hb7ea90af536c82a8c8df97106b978f5a;
    localparam logic [127:0] PC  = 128'h00000101030307070f0f1f1f3f3f7f7f;
    localparam logic [127:0] CD  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PD  = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         valid_in = 1'b1;
    logic [127:0] key_r    = KEY;
    logic [127:0] in_blk   = CA;
    logic [127:0] out_blk;
    logic         valid_out;

    exp_t         sb_q[$];
    int           cyc      = 0;
    int           checks   = 0;
    int           errors   = 0;
    bit           seen_rst = 1'b0;
    logic [127:0] hold     = '0;

    aes128_inverse_cipher dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key_r),
        .in        (in_blk),
        .valid_in  (valid_in),
        .out       (out_blk),
        .valid_out (valid_out)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic ok,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %032h expected %032h", name, cyc, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the next rising edge (cycle cyc+1) samples them.
    task automatic drive(input logic r, input logic v, input logic [127:0] d,
                         input logic [127:0] e);
        @(negedge clk);
        rst      = r;
        valid_in = v;
        in_blk   = d;
        if (v && !r)
            sb_q.push_back('{data: e, due: cyc + 11});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            seen_rst = 1'b1;
            sb_q.delete();
            hold = '0;
            check("rst_valid_out", valid_out === 1'b0, {127'd0, valid_out}, 128'd0);
            check("rst_out", out_blk === 128'd0, out_blk, 128'd0);
        end else if (seen_rst) begin
            if (valid_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 1'b0, out_blk, hold);
                end else begin
                    e = sb_q.pop_front();
                    check("data", out_blk === e.data, out_blk, e.data);
                    check("latency", e.due == cyc, 128'(cyc), 128'(e.due));
                    hold = e.data;
                end
            end else begin
                check("valid_low", valid_out === 1'b0, {127'd0, valid_out}, 128'd0);
                check("hold", out_blk === hold, out_blk, hold);
                if (sb_q.size() > 0 && sb_q[0].due <= cyc)
                    check("missing_output", 1'b0, 128'(cyc), 128'(sb_q[0].due));
            end
        end
    end

    initial begin
        // Two reset edges with valid_in high: nothing may be accepted.
        drive(1'b1, 1'b1, CA, PA);
        idle(14);

        // Single block.
        drive(1'b0, 1'b1, CA, PA);
        idle(14);

        // Back-to-back stream.
        drive(1'b0, 1'b1, CA, PA);
        drive(1'b0, 1'b1, CB, PB);
        drive(1'b0, 1'b1, CC, PC);
        idle(14);

        // Reset while the pipe is full, then the reordered pair.
        drive(1'b0, 1'b1, CA, PA);
        drive(1'b0, 1'b1, CB, PB);
        drive(1'b0, 1'b1, CC, PC);
        drive(1'b0, 1'b1, CA, PA);
        drive(1'b0, 1'b1, CB, PB);
        drive(1'b1, 1'b1, CC, PC);
        idle(14);
        drive(1'b0, 1'b1, CB, PB);
        drive(1'b0, 1'b1, CA, PA);
        idle(14);

        // Bubble between two blocks.
        drive(1'b0, 1'b1, CA, PA);
        idle(1);
        drive(1'b0, 1'b1, CB, PB);
        idle(14);

        // FIPS-197 Appendix C.1.
        drive(1'b0, 1'b1, CD, PD);
        idle(14);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size() == 0, 128'(sb_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes128_inverse_cipher.md
Name: aes128_inverse_cipher

Overview:
- Fully unrolled, fully pipelined AES-128 inverse cipher (FIPS-197 InvCipher).
- Accepts one 128-bit ciphertext block per clock, paired with a valid flag.
- Returns the matching plaintext a fixed number of cycles later, with a matching valid flag.
- Sits on the decrypt datapath beside the forward cipher. Uses the same byte ordering and valid-flag convention.

Parameters:
- Nk, 4: key length in 32-bit words. Only 4 (AES-128) is required; other values need not elaborate.
- Nr, 10: number of rounds. Only 10 is required; it sets the pipeline depth.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- key  input  Nk*32 (128)  cipher key. Ascending bit order [0:127]; bits 0..7 are key byte 0.
- in  input  128  ciphertext block. Ascending bit order [0:127]; bits 0..7 are state byte 0 (column-major state, as in FIPS-197).
- valid_in  input  1  qualifies "in" on the current edge.
- out  output  128  plaintext block, same byte ordering as "in".
- valid_out  output  1  qualifies "out".

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Key schedule:
  - Round keys w[0..43] are expanded combinationally from "key" using the standard expansion (SubWord, RotWord, Rcon).
  - "key" must be held stable while any block is in flight.
  - Changing "key" mid-flight corrupts in-flight blocks. This is not required to be detected.
- Pipeline: 11 register stages, all advancing every cycle with no stall input.
  - Stage 0 registers (in XOR round key 10) and valid_in.
  - Stages 1..9 each register one inverse round: InvShiftRows, InvSubBytes, AddRoundKey(round key 10-s), InvMixColumns.
  - Stage 10 registers the final round: InvShiftRows, InvSubBytes, AddRoundKey(round key 0), with no InvMixColumns. It drives "out".
- Latency:
  - A block sampled with valid_in=1 at rising edge n appears on "out" with valid_out=1 from edge n+10.
  - It stays there for exactly one cycle, unless the next block follows back-to-back.
- Throughput: one block per clock. Back-to-back blocks emerge on consecutive cycles in input order.
- valid_in low:
  - The stage valid bit is 0; the bubble propagates and valid_out is 0 in the corresponding cycle.
  - "out" holds its last valid plaintext when the final-stage valid bit is 0. Only valid blocks update "out".
  - Intermediate data registers may capture don't-care values.
- Reset (rst=1 at an edge):
  - All stage valid bits and valid_out go to 0.
  - "out" and all data registers go to 0.
- Reset mid-operation:
  - All in-flight blocks are discarded.
  - valid_out stays 0 until a block accepted after rst deasserts reaches stage 10.
  - A block sampled at an edge where rst=1 is dropped.
- S-boxes: the inverse S-box (datapath) and forward S-box (key schedule) may be ROM tables or GF(2^8)-inverse logic. They must be bit-exact to FIPS-197.
- InvMixColumns: matrix {0e,0b,0d,09}, computed with xtime chains over GF(2^8), polynomial 0x11b.
- No X on "out" or valid_out after the first reset.

Test Plan:
- Reset: hold rst=1 for 2 edges with valid_in=1 -> valid_out=0 and out=0 throughout; nothing emerges after release until a new block propagates.
- Single block: key=000102030405060708090a0b0c0d0e0f, in=0a940bb5416ef045f1c39458c653ea5a sampled at edge n -> out=000102030405060708090a0b0c0d0e0f with valid_out=1 at edge n+10 only.
- Back-to-back stream, same key, on consecutive edges:
  - Input: 0a940bb5416ef045f1c39458c653ea5a, 20a9f992b44c5be8041ffcdc6cae996a, b7ea90af536c82a8c8df97106b978f5a.
  - Required: out = 000102030405060708090a0b0c0d0e0f, 0f0e0d0c0b0a09080706050403020100, 00000101030307070f0f1f1f3f3f7f7f on three consecutive cycles, valid_out high for exactly those three cycles.
- Reset mid-flight then reorder: assert rst while blocks are in the pipe -> valid_out drops at the next edge, with no stale output after release. Then feed 20a9f992... followed by 0a940bb5... -> outputs 0f0e0d0c... then 000102..0f, in that order.
- Bubble: feed block A, one cycle with valid_in=0, then block B -> valid_out pattern 1,0,1; out holds A during the bubble cycle.
- FIPS-197 C.1 vector: in=69c4e0d86a7b0430d8cdb78070b4c55a with the same key -> out=00112233445566778899aabbccddeeff.
